// File: rtl/uart_prog_loader.sv
// Boot loader: receives program bytes over an 8N1 UART, packs them little-endian into
// 32-bit words, writes them to instruction memory and releases the core on END_WORD.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  output logic              core_rst_no,
  output logic              load_done_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_LOAD, LD_WRITE, LD_DONE} ld_state_e;

  rx_state_e         rx_state, rx_next;
  ld_state_e         ld_state, ld_next;
  logic              rx_p0, rx_p1, rx_p2;
  logic              rx_fall;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_hit, cnt_restart;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              shift_en, byte_vld, stop_err;
  logic              rx_active, byte_ok;
  logic [1:0]        byte_idx;
  logic [23:0]       word_lo;
  logic              word_cmpl;
  logic [31:0]       new_word;
  logic              latch_word, write_adv, overrun_set;

  // ---- stage p0/p1: two-flop synchronizer, p2 holds previous level for edge detect
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_fall = rx_p2 & ~rx_p1;
  assign cnt_hit = (rx_state == RX_START) ? (cnt == HALF_M1) : (cnt == BIT_M1);

  // ---- RX bit-timing FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    cnt_restart = 1'b0;
    shift_en    = 1'b0;
    byte_vld    = 1'b0;
    stop_err    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_restart = 1'b1;
        if (rx_fall) rx_next = RX_START;
      end
      RX_START: begin
        if (cnt_hit) begin
          cnt_restart = 1'b1;
          // A line that is high again at mid-start was only a glitch.
          rx_next     = rx_p1 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_hit) begin
          cnt_restart = 1'b1;
          shift_en    = 1'b1;
          if (bit_idx == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_hit) begin
          cnt_restart = 1'b1;
          rx_next     = RX_IDLE;
          if (rx_p1) byte_vld = 1'b1;
          else       stop_err = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= cnt_restart ? '0 : cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= '0;
      else if (shift_en)        bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift <= {rx_p1, shift[7:1]};
    end
  end

  // ---- byte assembly into little-endian words; RX is ignored once loading is done
  assign rx_active = (ld_state != LD_DONE);
  assign byte_ok   = byte_vld & rx_active;
  assign word_cmpl = byte_ok & (byte_idx == 2'd3);
  assign new_word  = {shift, word_lo};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      byte_idx <= '0;
      word_lo  <= '0;
    end else if (byte_ok) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    word_lo[7:0]   <= shift;
        2'd1:    word_lo[15:8]  <= shift;
        2'd2:    word_lo[23:16] <= shift;
        default: word_lo        <= word_lo;
      endcase
    end
  end

  // ---- load FSM and memory write port
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ld_state <= LD_LOAD;
    else         ld_state <= ld_next;
  end

  always_comb begin
    ld_next     = ld_state;
    latch_word  = 1'b0;
    write_adv   = 1'b0;
    overrun_set = 1'b0;
    case (ld_state)
      LD_LOAD: begin
        if (word_cmpl) begin
          if (new_word == END_WORD) begin
            ld_next = LD_DONE;
          end else begin
            latch_word = 1'b1;
            ld_next    = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        // A word finishing while the request is still up is dropped, even on the grant cycle.
        if (word_cmpl) overrun_set = 1'b1;
        if (mem_gnt_i) begin
          write_adv = 1'b1;
          ld_next   = LD_LOAD;
        end
      end
      LD_DONE: ld_next = LD_DONE;
      default: ld_next = LD_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_wdata_o  <= '0;
      mem_addr_o   <= '0;
      word_count_o <= '0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (latch_word) mem_wdata_o <= new_word;
      if (write_adv) begin
        mem_addr_o <= mem_addr_o + 1'b1;
        if (word_count_o != '1) word_count_o <= word_count_o + 1'b1;
      end
      if (stop_err && rx_active) frame_err_o <= 1'b1;
      if (overrun_set)           overrun_o   <= 1'b1;
    end
  end

  assign mem_req_o   = (ld_state == LD_WRITE);
  assign mem_we_o    = mem_req_o;
  assign mem_be_o    = 4'hF;
  assign core_rst_no = (ld_state == LD_DONE);
  assign load_done_o = (ld_state == LD_DONE);

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Boot-time program loader that receives instruction bytes serially on the SoC instruction UART pin, assembles them little-endian into 32-bit words, and writes them sequentially into instruction memory over a req/gnt port. It holds the core in reset while loading and releases it when the end-of-program word arrives. It sits between the `uart_rx_inst` pad and the instruction-memory write port inside `opentitan_soc_top`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10417: clocks per UART bit (100 MHz / 9600 baud); minimum 8.
- `ADDR_W`, default 12: word-address width of the instruction memory.
- `END_WORD`, default 32'h0000_0FFF: terminator word; it is never written to memory.

Ports:
- `clk_i`  in  1  single system clock.
- `rst_ni`  in  1  reset; synchronous and active-low.
- `rx_i`  in  1  asynchronous UART line, idle high, 8N1, LSB first.
- `mem_req_o`  out  1  write request; held until granted.
- `mem_we_o`  out  1  write enable; equal to `mem_req_o`.
- `mem_addr_o`  out  ADDR_W  word address.
- `mem_wdata_o`  out  32  `{b3,b2,b1,b0}`, where b0 is the first byte received.
- `mem_be_o`  out  4  byte enables; always 4'hF.
- `mem_gnt_i`  in  1  write accepted in the cycle it is high while `mem_req_o` is high.
- `core_rst_no`  out  1  core reset, active-low; low until loading completes.
- `load_done_o`  out  1  sticky; high once END_WORD is received.
- `frame_err_o`  out  1  sticky; a stop bit was sampled low.
- `overrun_o`  out  1  sticky; a word completed while the previous write was still pending.
- `word_count_o`  out  ADDR_W+1  number of words written; saturates at all-ones.

## Operation
- **Input synchronizer:** `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge.
  - START waits `CLKS_PER_BIT/2` (integer division), then re-samples the line. Low → DATA. High → IDLE (glitch; nothing recorded).
  - DATA takes 8 samples spaced `CLKS_PER_BIT` apart, LSB first, then → STOP.
  - STOP samples once after `CLKS_PER_BIT`. High → the byte is valid (`byte_vld` pulse for 1 cycle). Low → set `frame_err_o`, discard the byte, leave the byte index unchanged. Either outcome → IDLE.
- **Byte assembly:** a 2-bit index selects the target byte lane; it wraps 3→0. When the 4th byte is valid the word is complete.
- **Load FSM states:** LOAD, WRITE, DONE.
  - LOAD, on word complete: word == END_WORD → DONE. Otherwise latch the data into `mem_wdata_o` and go to WRITE.
  - WRITE: `mem_req_o` = 1, with address and data held stable. On `mem_gnt_i`: address increments, `word_count_o` increments, → LOAD.
  - WRITE, if another word completes while `mem_req_o` is still high: set `overrun_o` and drop the new word. The pending write is unaffected.
  - DONE: `core_rst_no` = 1 and `load_done_o` = 1. All further RX traffic is ignored (errors are not updated). DONE is left only by reset.
- **Address arithmetic:** the address wraps from 2^ADDR_W−1 to 0. `word_count_o` does not wrap; it saturates.
- **Reset mid-operation:** every register returns to its reset value. A partially received byte or word is discarded, and the core is held in reset again.

## Timing
- **Reset values:** `mem_req_o`/`mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, `mem_be_o` 4'hF, `core_rst_no` 0, `load_done_o` 0, `frame_err_o` 0, `overrun_o` 0, `word_count_o` 0. RX FSM in IDLE, load FSM in LOAD, byte index 0.
- **Byte latency:** `byte_vld` asserts 2 (synchronizer) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the falling edge on `rx_i`. One cycle of edge-detect uncertainty is allowed.
- **Write request:** `mem_req_o` rises in the cycle after the 4th byte's `byte_vld`.
- **Grant:** with `mem_gnt_i` high in the same cycle as the request, the write completes in one cycle. Back-to-back grants are never needed, since at most one write is outstanding.
- **Core release:** `core_rst_no` and `load_done_o` rise in the cycle after END_WORD completes.
- **Errors:** `frame_err_o` is set in the cycle after the STOP sample. `overrun_o` is set in the cycle after the offending word completes.

## Test plan
Benches use `CLKS_PER_BIT` = 16 and `ADDR_W` = 4.
1. **Single word:** send bytes 0x13,0x01,0x20,0x00 with `mem_gnt_i` tied high → exactly one write, addr 0, data 0x00200113, be 0xF. `word_count_o` = 1; `core_rst_no` stays 0.
2. **Grant delay and end word:** three words with `mem_gnt_i` delayed 5 cycles, then 0xFF,0x0F,0x00,0x00 → writes to addr 0,1,2 with address/data stable while `mem_req_o` is high. Then END_WORD → no 4th write; `core_rst_no` = 1 and `load_done_o` = 1 one cycle later; a further byte causes no write.
3. **Glitch and framing error:**
   - a 4-cycle low pulse on `rx_i` → no byte and no error.
   - a byte with stop bit 0 → `frame_err_o` = 1, byte discarded. The next 4 good bytes form a word at addr 0.
4. **Overrun:** hold `mem_gnt_i` low across two complete words → `overrun_o` = 1. On release, only the first word is written.
5. **Address wrap:** 17 words → the 17th is written to addr 0 and `word_count_o` = 17.
6. **Reset mid-operation:** assert `rst_ni` low for 1 cycle after 2 bytes of a word → all outputs return to reset values. The next 4 bytes form a word at addr 0.
